// File: rtl/microcode_rom.sv
// microcode_rom: 64-entry synchronous control store for the accumulator CPU.
// Ports: clk, rst_n (async, active-low), offset[5:0] in; mc_word[19:0] out.

`ifndef MCROM_WIDTH
`define MCROM_WIDTH 20
`endif

module microcode_rom (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5:0]              offset,
  output logic [`MCROM_WIDTH-1:0] mc_word
);

  localparam int W = `MCROM_WIDTH;

  typedef logic [W-1:0] word_t;

  localparam word_t NOP    = 20'h00000;
  localparam word_t FETCH1 = 20'h04040;
  localparam word_t FETCH2 = 20'h08114;
  localparam word_t DECODE = 20'h01000;
  localparam word_t LDA1   = 20'h24020;
  localparam word_t LDA2   = 20'h00012;
  localparam word_t ADD1   = 20'h34020;
  localparam word_t ADD2   = 20'h00212;
  localparam word_t SUB1   = 20'h44020;
  localparam word_t SUB2   = 20'h00412;
  localparam word_t AND1   = 20'h54020;
  localparam word_t AND2   = 20'h00612;
  localparam word_t STA1   = 20'h64020;
  localparam word_t STA2   = 20'h00E08;
  localparam word_t JMP    = 20'h00080;
  localparam word_t JZ1    = 20'h86000;
  localparam word_t JZ2    = 20'h00080;
  localparam word_t HLT    = 20'h90001;

  word_t rom_d;
  word_t mc_word_q;

  // Unlisted addresses decode to NOP, which falls back to FETCH1.
  always_comb begin
    rom_d = NOP;
    case (offset)
      6'd0:    rom_d = FETCH1;
      6'd1:    rom_d = FETCH2;
      6'd2:    rom_d = DECODE;
      6'd8:    rom_d = LDA1;
      6'd9:    rom_d = LDA2;
      6'd12:   rom_d = ADD1;
      6'd13:   rom_d = ADD2;
      6'd16:   rom_d = SUB1;
      6'd17:   rom_d = SUB2;
      6'd20:   rom_d = AND1;
      6'd21:   rom_d = AND2;
      6'd24:   rom_d = STA1;
      6'd25:   rom_d = STA2;
      6'd28:   rom_d = JMP;
      6'd32:   rom_d = JZ1;
      6'd33:   rom_d = JZ2;
      6'd36:   rom_d = HLT;
      default: rom_d = NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_word_q <= NOP;
    end else begin
      mc_word_q <= rom_d;
    end
  end

  assign mc_word = mc_word_q;

endmodule

// File: tb/tb_microcode_rom.sv
// tb_microcode_rom: scoreboard bench for microcode_rom.
// Driver queues expected words; monitor pops and compares after each edge.

module tb_microcode_rom;

  localparam int W = 20;

  typedef struct {
    logic [W-1:0] exp;
    bit           care;
    int           addr;
  } item_t;

  logic         clk;
  logic         rst_n;
  logic [5:0]   offset;
  logic [W-1:0] mc_word;

  logic [W-1:0] ref_rom [64];
  item_t        sb_q [$];
  logic [W-1:0] prev_exp;
  bit           prev_care;
  bit           run;
  int           errors;
  int           checks;

  microcode_rom dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .offset  (offset),
    .mc_word (mc_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %05h want %05h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: the documented control-store table.
  initial begin
    for (int i = 0; i < 64; i++) ref_rom[i] = '0;
    ref_rom[0]  = 20'h04040;
    ref_rom[1]  = 20'h08114;
    ref_rom[2]  = 20'h01000;
    ref_rom[8]  = 20'h24020;
    ref_rom[9]  = 20'h00012;
    ref_rom[12] = 20'h34020;
    ref_rom[13] = 20'h00212;
    ref_rom[16] = 20'h44020;
    ref_rom[17] = 20'h00412;
    ref_rom[20] = 20'h54020;
    ref_rom[21] = 20'h00612;
    ref_rom[24] = 20'h64020;
    ref_rom[25] = 20'h00E08;
    ref_rom[28] = 20'h00080;
    ref_rom[32] = 20'h86000;
    ref_rom[33] = 20'h00080;
    ref_rom[36] = 20'h90001;
  end

  // Monitor: one queued expectation per active clock edge.
  always @(posedge clk) begin
    if (run && rst_n) begin
      #1;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: no expected word at %0t", $time);
      end else begin
        item_t it;
        it = sb_q.pop_front();
        if (it.care) chk($sformatf("word@%0d", it.addr), mc_word, it.exp);
      end
    end
  end

  // Present an address mid-cycle, confirm the output has not moved yet,
  // then let one edge pass.
  task automatic step(input int a);
    item_t it;
    offset = a[5:0];
    it.exp = ref_rom[a];
    it.care = 1'b1;
    it.addr = a;
    sb_q.push_back(it);
    #3;
    if (prev_care) chk("hold", mc_word, prev_exp);
    prev_exp = it.exp;
    prev_care = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic step_x();
    item_t it;
    offset = 'x;
    it.exp = '0;
    it.care = 1'b0;
    it.addr = -1;
    sb_q.push_back(it);
    prev_care = 1'b0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    run = 1'b0;
    prev_exp = '0;
    prev_care = 1'b1;
    rst_n = 1'b0;
    offset = 6'd1;

    // Reset held across several edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", mc_word, 20'h00000);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run = 1'b1;

    // Sweep, then wrap 63 -> 0.
    for (int a = 0; a < 64; a++) step(a);
    step(0);
    step(1);

    // Latency 8 -> 13.
    step(8);
    step(13);

    // Field decode.
    step(2);
    chk("dec_seq", {18'd0, mc_word[13:12]}, 20'd1);
    chk("dec_next", {14'd0, mc_word[19:14]}, 20'd0);
    step(32);
    chk("jz_seq", {18'd0, mc_word[13:12]}, 20'd2);
    chk("jz_next", {14'd0, mc_word[19:14]}, 20'd33);
    step(25);
    chk("sta_alu", {17'd0, mc_word[11:9]}, 20'd7);
    chk("sta_wr", {19'd0, mc_word[3]}, 20'd1);

    // Reset pulse between edges.
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_async", mc_word, 20'h00000);
    #2;
    chk("reset_low", mc_word, 20'h00000);
    rst_n = 1'b1;
    prev_exp = '0;
    step(36);
    step(36);

    // X on the address must not disturb following cycles.
    step_x();
    step(12);
    step(1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      if ((i % 4) == 0) step(8 + 4 * $urandom_range(0, 7));
      else step($urandom_range(0, 63));
    end

    run = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d left, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/microcode_rom.md
# microcode_rom

Synchronous 64-entry microcode ROM for the microcoded accumulator CPU. The microsequencer drives a 6-bit microaddress (`offset`). The ROM returns the registered control word (`mc_word`) that drives the datapath and selects the next microaddress. Contents are fixed at synthesis; there is no write port.

## Interface
- No parameters.
- Word width is the global define `MCROM_WIDTH` from microcodedefs.v, fixed at 20.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `offset`  input  6  microaddress, 0–63.
- `mc_word`  output  `MCROM_WIDTH` (20)  registered microinstruction.

## Operation
Word fields:
- [19:14] NEXT: next microaddress.
- [13:12] SEQ:
  - 0 = go to NEXT.
  - 1 = DISPATCH: go to 8 + 4·opcode.
  - 2 = JZ: go to NEXT if ACC==0, else go to 0.
  - 3 = reserved.
- [11:9] ALU op: 0 PASSB, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOTA, 7 PASSA.
- Control bits:
  - [8] PC_INC
  - [7] PC_LD (PC←IR operand)
  - [6] MAR_PC
  - [5] MAR_IR
  - [4] MEM_RD
  - [3] MEM_WR
  - [2] IR_LD
  - [1] ACC_LD
  - [0] HALT

ROM contents (hex, 20-bit). Every address not listed holds 0x00000.
- 0 FETCH1 = 0x04040
- 1 FETCH2 = 0x08114
- 2 DECODE = 0x01000
- 8 LDA.1 = 0x24020; 9 LDA.2 = 0x00012
- 12 ADD.1 = 0x34020; 13 ADD.2 = 0x00212
- 16 SUB.1 = 0x44020; 17 SUB.2 = 0x00412
- 20 AND.1 = 0x54020; 21 AND.2 = 0x00612
- 24 STA.1 = 0x64020; 25 STA.2 = 0x00E08
- 28 JMP = 0x00080
- 32 JZ.1 = 0x86000; 33 JZ.2 = 0x00080
- 36 HLT = 0x90001 (self-loop with HALT)

Rules:
- The ROM does not interpret fields. The layout above documents the required bit values and is used by the sequencer and datapath.
- 0x00000 is the NOP word: NEXT=0, SEQ=NEXT, no controls. An unused address therefore returns to FETCH1.
- All 64 addresses are valid; there is no out-of-range case.
- Implement as a case statement or initialized array. Contents must be identical in simulation and synthesis.

## Timing
- Rising edge of `clk` with `rst_n` high: `mc_word` ← ROM[`offset`].
- Latency is exactly 1 cycle from `offset` to `mc_word`. There is no combinational path from `offset` to `mc_word`.
- `rst_n` low: `mc_word` = 0x00000 immediately, independent of `clk`, and is held while `rst_n` stays low.
- First rising edge after `rst_n` deasserts: `mc_word` loads ROM[`offset`] as normal. Deassertion is assumed synchronous to `clk` by the system.
- Reset asserted mid-stream: the output clears at once. The address presented on the first clock after release is honoured with no stale data.
- Back-to-back changes of `offset` on every cycle are supported. Each cycle's output reflects the `offset` sampled at the previous edge.
- `offset` X/Z: output content is don't-care, but must not corrupt later cycles.

## Test plan
- Reset: hold `rst_n`=0 with `offset`=1 and clock toggling -> `mc_word`=0x00000. Assert `rst_n` low between edges -> output clears before the next edge.
- Sweep: release reset, increment `offset` 0→63 on each rising edge -> the word for each address appears one cycle later. Check 0x04040, 0x08114, 0x01000, 0x24020, …, 0x90001, and 0x00000 at every unlisted address.
- Wrap-around: `offset` 63→0 -> 0x00000 then 0x04040 on consecutive cycles.
- Latency: change `offset` 8→13 mid-cycle -> `mc_word` stays at the prior value until the next rising edge, then shows 0x24020, then 0x00212.
- Reset mid-run: at `offset`=25 pulse `rst_n` low for 3 ns between edges -> immediate 0x00000. The next edge after release with `offset`=36 -> 0x90001.
- Field decode: read address 2 -> SEQ=1, NEXT=0. Read address 32 -> SEQ=2, NEXT=33. Read address 25 -> ALU=7, MEM_WR=1.
